dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, giving the line index width (16 lines of one 32-bit word each).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_read  input  1  pipeline load request.
REQ-005 SHALL have port mem_write  input  2  pipeline store request; any nonzero value means a word store.
REQ-006 SHALL have port addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port wdata  input  32  store data.
REQ-008 SHALL have port rdata  output  32  load data.
REQ-009 SHALL have port stall  output  1  freeze pipeline; request held stable by requester while high.
REQ-010 SHALL have port mem_req  output  1  backing-memory request.
REQ-011 SHALL have port mem_we  output  1  backing-memory write enable.
REQ-012 SHALL have port mem_addr  output  32  word-aligned backing-memory address.
REQ-013 SHALL have port mem_wdata  output  32  backing-memory write data.
REQ-014 SHALL have port mem_rdata  input  32  backing-memory read data, valid with mem_ack.
REQ-015 SHALL have port mem_ack  input  1  one-cycle completion pulse from backing memory.

Function
REQ-016 SHALL split addr as index = addr[INDEX_BITS+1:2] and tag = addr[31:INDEX_BITS+2]; each line holds a valid bit, a tag and one data word.
REQ-017 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-018 In IDLE, SHALL treat mem_write nonzero as a store, and mem_read with mem_write==0 as a load; when both are set, the store wins and the load is ignored.
REQ-019 In IDLE on a load hit (valid and tag match), SHALL drive rdata from the line and hold stall=0 in the same cycle, with no memory request.
REQ-020 In IDLE on a load miss, SHALL assert stall combinationally in that cycle, latch addr, and enter FILL.
REQ-021 In IDLE on any store, SHALL assert stall combinationally, latch addr and wdata, and enter WRITE; the policy is write-through.
REQ-022 In FILL, SHALL hold mem_req=1, mem_we=0, mem_addr={latched addr[31:2],2'b00}, stall=1 until mem_ack.
REQ-023 On mem_ack in FILL, SHALL write mem_rdata, the tag and valid=1 into the indexed line, then enter DONE.
REQ-024 In WRITE, SHALL hold mem_req=1, mem_we=1, mem_addr aligned, mem_wdata=latched wdata, stall=1 until mem_ack.
REQ-025 On mem_ack in WRITE, SHALL update the line data if the latched address hits, SHALL NOT allocate on a miss, then enter DONE.
REQ-026 In DONE, SHALL drive stall=0 and rdata = indexed line data for exactly one cycle, then return to IDLE.
REQ-027 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable from assertion until the mem_ack cycle, and SHALL deassert mem_req in the cycle after mem_ack.
REQ-028 SHALL ignore mem_ack when mem_req=0, and SHALL ignore pipeline inputs outside IDLE.
REQ-029 SHALL drive rdata=0 whenever no load data is being returned.
REQ-030 Load-miss latency: stall high from the request cycle through the ack cycle, data returned in the following (DONE) cycle.

Reset
REQ-031 While rst is high, SHALL force state=IDLE, clear all valid bits, and drive stall=0, mem_req=0, mem_we=0, rdata=0, mem_addr=0, mem_wdata=0.
REQ-032 When rst is asserted mid-FILL or mid-WRITE, SHALL abort immediately with no line update, and SHALL ignore any later mem_ack.

Verification
REQ-033 Load miss then hit: after reset, read 0x100 -> stall=1, mem_req=1, mem_we=0, mem_addr=0x100; ack 3 cycles later with 0xDEADBEEF -> next cycle stall=0, rdata=0xDEADBEEF; re-read 0x100 -> hit, stall=0, no mem_req.
REQ-034 Store hit: with 0x100 cached, write 0x12345678 to 0x100 -> mem_req=1, mem_we=1, mem_wdata=0x12345678; after ack and DONE, read 0x100 -> hit returning 0x12345678.
REQ-035 Store miss: write to 0x200 (uncached) -> memory write completes; subsequent read 0x200 -> miss (FILL entered).
REQ-036 Conflict eviction: fill 0x100, then fill 0x140 (same index 0) -> read 0x100 misses, read 0x140 hits.
REQ-037 Reset mid-FILL: read 0x140 miss, assert rst before ack -> mem_req=0 at once; a late ack is ignored; read 0x140 -> miss.
REQ-038 Simultaneous request: mem_read=1, mem_write=2'b01 at 0x100 -> only a write transaction (mem_we=1) is issued, followed by one DONE cycle.

Source files
------------

// File: rtl/dcache_if.sv
// Bundle of pipeline-side and backing-memory-side signals for the data cache
// controller. The slave modport is the cache's view; the master modport is
// the view of whatever drives the pipeline requests and models the memory.
interface dcache_if;
   logic        mem_read;
   logic [1:0]  mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  mem_read, mem_write, addr, wdata, mem_rdata, mem_ack,
      output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output mem_read, mem_write, addr, wdata, mem_rdata, mem_ack,
      input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One 32-bit word per line. Load hits complete in the request cycle. Load
// misses and all stores stall the pipeline and run a single backing-memory
// transaction, followed by one DONE cycle that releases the stall.
module dcache_ctrl #(
   parameter int INDEX_BITS = 4
) (
   input logic     clk,
   input logic     rst,
   dcache_if.slave bus
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 32 - INDEX_BITS - 2;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic                valid_q [LINES];
   logic                valid_d [LINES];
   logic [TAG_BITS-1:0] tag_q   [LINES];
   logic [TAG_BITS-1:0] tag_d   [LINES];
   logic [31:0]         data_q  [LINES];
   logic [31:0]         data_d  [LINES];

   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] lat_index;
   logic [TAG_BITS-1:0]   lat_tag;
   logic                  req_hit;
   logic                  lat_hit;

   logic        stall_o;
   logic [31:0] rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;

   // Byte-offset bits are never used; collect them so they are visibly sunk.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr[1:0], addr_q[1:0]};

   assign req_index = bus.addr[INDEX_BITS+1:2];
   assign req_tag   = bus.addr[31:INDEX_BITS+2];
   assign lat_index = addr_q[INDEX_BITS+1:2];
   assign lat_tag   = addr_q[31:INDEX_BITS+2];
   assign req_hit   = valid_q[req_index] && (tag_q[req_index] == req_tag);
   assign lat_hit   = valid_q[lat_index] && (tag_q[lat_index] == lat_tag);

   // Next-state, line update and output decode; outputs are forced quiet while reset is held.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      stall_o     = 1'b0;
      rdata_o     = 32'h0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;

      case (state_q)
         IDLE: begin
            if (bus.mem_write != 2'b00) begin
               stall_o = 1'b1;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               state_d = WRITE;
            end else if (bus.mem_read) begin
               if (req_hit) begin
                  rdata_o = data_q[req_index];
               end else begin
                  stall_o = 1'b1;
                  addr_d  = bus.addr;
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            stall_o    = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = {addr_q[31:2], 2'b00};
            if (bus.mem_ack) begin
               data_d[lat_index]  = bus.mem_rdata;
               tag_d[lat_index]   = lat_tag;
               valid_d[lat_index] = 1'b1;
               state_d            = DONE;
            end
         end
         WRITE: begin
            stall_o     = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            mem_wdata_o = wdata_q;
            if (bus.mem_ack) begin
               if (lat_hit) begin
                  data_d[lat_index] = wdata_q;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            rdata_o = data_q[lat_index];
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst) begin
         stall_o     = 1'b0;
         rdata_o     = 32'h0;
         mem_req_o   = 1'b0;
         mem_we_o    = 1'b0;
         mem_addr_o  = 32'h0;
         mem_wdata_o = 32'h0;
      end
   end

   // State, latched request and line storage; reset invalidates every line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         valid_q <= '{default: 1'b0};
         tag_q   <= '{default: '0};
         data_q  <= '{default: 32'h0};
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign bus.stall     = stall_o;
   assign bus.rdata     = rdata_o;
   assign bus.mem_req   = mem_req_o;
   assign bus.mem_we    = mem_we_o;
   assign bus.mem_addr  = mem_addr_o;
   assign bus.mem_wdata = mem_wdata_o;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a per-cycle vector table for the main
// cache scenarios, plus hand-written sequences around reset.
module tb_dcache_ctrl;

   logic clk = 1'b0;
   logic rst;

   dcache_if bus ();

   dcache_ctrl #(.INDEX_BITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   int num_checks = 0;
   int num_fails  = 0;

   typedef struct {
      string       name;
      logic        rd;
      logic [1:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] mrdata;
      logic        stall;
      logic [31:0] rdata;
      logic        req;
      logic        we;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input string name, input logic rd, input logic [1:0] wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic ack, input logic [31:0] mrd,
                         input logic st, input logic [31:0] rdv,
                         input logic rq, input logic we,
                         input logic [31:0] ma, input logic [31:0] mwd);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
      v.ack = ack; v.mrdata = mrd; v.stall = st; v.rdata = rdv;
      v.req = rq; v.we = we; v.maddr = ma; v.mwdata = mwd;
      vecs.push_back(v);
   endtask

   // Drive one cycle of pipeline and memory inputs just after the rising edge.
   task automatic applyStimulus(input logic rd, input logic [1:0] wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic ack, input logic [31:0] mrd);
      @(posedge clk);
      #1;
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.addr      = a;
      bus.wdata     = wd;
      bus.mem_ack   = ack;
      bus.mem_rdata = mrd;
   endtask

   task automatic checkField(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_fails++;
         $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
      end
   endtask

   // Sample all outputs on the falling edge, mid-cycle.
   task automatic checkOutput(input string name, input logic st, input logic [31:0] rdv,
                              input logic rq, input logic we,
                              input logic [31:0] ma, input logic [31:0] mwd);
      @(negedge clk);
      checkField(name, "stall",     {31'h0, bus.stall},   {31'h0, st});
      checkField(name, "rdata",     bus.rdata,            rdv);
      checkField(name, "mem_req",   {31'h0, bus.mem_req}, {31'h0, rq});
      checkField(name, "mem_we",    {31'h0, bus.mem_we},  {31'h0, we});
      checkField(name, "mem_addr",  bus.mem_addr,         ma);
      checkField(name, "mem_wdata", bus.mem_wdata,        mwd);
   endtask

   initial begin
      // Each row is one clock cycle: inputs, then the outputs expected in that cycle.
      //       name            rd  wr     addr      wdata         ack mrdata        stall rdata         req we maddr     mwdata
      addVec("ld_miss",        1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("fill_w1",        1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0, 32'h100, 32'h0);
      addVec("fill_w2",        1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0, 32'h100, 32'h0);
      addVec("fill_ack",       1, 2'b00, 32'h100, 32'h0,         1, 32'hDEADBEEF,  1, 32'h0,         1, 0, 32'h100, 32'h0);
      addVec("fill_done",      1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF,  0, 0, 32'h0,   32'h0);
      addVec("ld_hit",         1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF,  0, 0, 32'h0,   32'h0);
      addVec("st_hit_req",     0, 2'b01, 32'h100, 32'h12345678,  0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("st_hit_w1",      0, 2'b01, 32'h100, 32'h12345678,  0, 32'h0,         1, 32'h0,         1, 1, 32'h100, 32'h12345678);
      addVec("st_hit_ack",     0, 2'b01, 32'h100, 32'h12345678,  1, 32'h0,         1, 32'h0,         1, 1, 32'h100, 32'h12345678);
      addVec("st_hit_done",    0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'h12345678,  0, 0, 32'h0,   32'h0);
      addVec("ld_after_st",    1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         0, 32'h12345678,  0, 0, 32'h0,   32'h0);
      addVec("st_miss_req",    0, 2'b10, 32'h200, 32'hCAFEF00D,  0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("st_miss_ack",    0, 2'b10, 32'h200, 32'hCAFEF00D,  1, 32'h0,         1, 32'h0,         1, 1, 32'h200, 32'hCAFEF00D);
      addVec("st_miss_done",   0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'h12345678,  0, 0, 32'h0,   32'h0);
      addVec("ld200_miss",     1, 2'b00, 32'h200, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("ld200_ack",      1, 2'b00, 32'h200, 32'h0,         1, 32'h0BADF00D,  1, 32'h0,         1, 0, 32'h200, 32'h0);
      addVec("ld200_done",     0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'h0BADF00D,  0, 0, 32'h0,   32'h0);
      addVec("ld100_miss",     1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("ld100_ack",      1, 2'b00, 32'h100, 32'h0,         1, 32'hAAAA0100,  1, 32'h0,         1, 0, 32'h100, 32'h0);
      addVec("ld100_done",     0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'hAAAA0100,  0, 0, 32'h0,   32'h0);
      addVec("ld140_miss",     1, 2'b00, 32'h140, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("ld140_ack",      1, 2'b00, 32'h140, 32'h0,         1, 32'hBBBB0140,  1, 32'h0,         1, 0, 32'h140, 32'h0);
      addVec("ld140_done",     0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'hBBBB0140,  0, 0, 32'h0,   32'h0);
      addVec("ld140_hit",      1, 2'b00, 32'h140, 32'h0,         0, 32'h0,         0, 32'hBBBB0140,  0, 0, 32'h0,   32'h0);
      addVec("evicted_miss",   1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("evicted_ack",    1, 2'b00, 32'h100, 32'h0,         1, 32'hAAAA0100,  1, 32'h0,         1, 0, 32'h100, 32'h0);
      addVec("evicted_done",   0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'hAAAA0100,  0, 0, 32'h0,   32'h0);
      addVec("both_req",       1, 2'b01, 32'h100, 32'h55667788,  0, 32'h0,         1, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("both_w1",        1, 2'b01, 32'h100, 32'h55667788,  0, 32'h0,         1, 32'h0,         1, 1, 32'h100, 32'h55667788);
      addVec("both_ack",       1, 2'b01, 32'h100, 32'h55667788,  1, 32'h0,         1, 32'h0,         1, 1, 32'h100, 32'h55667788);
      addVec("both_done",      1, 2'b01, 32'h100, 32'h55667788,  0, 32'h0,         0, 32'h55667788,  0, 0, 32'h0,   32'h0);
      addVec("idle_quiet",     0, 2'b00, 32'h0,   32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("stray_ack",      0, 2'b00, 32'h100, 32'h0,         1, 32'hFFFFFFFF,  0, 32'h0,         0, 0, 32'h0,   32'h0);
      addVec("ld_after_both",  1, 2'b00, 32'h100, 32'h0,         0, 32'h0,         0, 32'h55667788,  0, 0, 32'h0,   32'h0);

      // Reset held with a request present: every output stays quiet.
      rst           = 1'b1;
      bus.mem_read  = 1'b1;
      bus.mem_write = 2'b01;
      bus.addr      = 32'h100;
      bus.wdata     = 32'h1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      checkOutput("in_reset", 0, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
      rst = 1'b0;
      checkOutput("after_reset", 0, 32'h0, 0, 0, 32'h0, 32'h0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       vecs[i].ack, vecs[i].mrdata);
         checkOutput(vecs[i].name, vecs[i].stall, vecs[i].rdata, vecs[i].req,
                     vecs[i].we, vecs[i].maddr, vecs[i].mwdata);
      end

      // Reset in the middle of a fill: abort at once, then a late ack must be ignored.
      applyStimulus(1, 2'b00, 32'h140, 32'h0, 0, 32'h0);
      checkOutput("rf_miss", 1, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 2'b00, 32'h140, 32'h0, 0, 32'h0);
      checkOutput("rf_fill", 1, 32'h0, 1, 0, 32'h140, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("rf_abort", 0, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 2'b00, 32'h0, 32'h0, 1, 32'h99999999);
      rst = 1'b0;
      checkOutput("rf_late_ack", 0, 32'h0, 0, 0, 32'h0, 32'h0);

      // Line 0 held 0x100 before reset; reset must have invalidated it.
      applyStimulus(1, 2'b00, 32'h100, 32'h0, 0, 32'h0);
      checkOutput("rf_100_miss", 1, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 2'b00, 32'h100, 32'h0, 1, 32'h11110100);
      checkOutput("rf_100_ack", 1, 32'h0, 1, 0, 32'h100, 32'h0);
      applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
      checkOutput("rf_100_done", 0, 32'h11110100, 0, 0, 32'h0, 32'h0);

      // The aborted fill must not have installed 0x140.
      applyStimulus(1, 2'b00, 32'h140, 32'h0, 0, 32'h0);
      checkOutput("rf_140_miss", 1, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 2'b00, 32'h140, 32'h0, 1, 32'h0140C0DE);
      checkOutput("rf_140_ack", 1, 32'h0, 1, 0, 32'h140, 32'h0);
      applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
      checkOutput("rf_140_done", 0, 32'h0140C0DE, 0, 0, 32'h0, 32'h0);

      // Reset in the middle of a store: no line update, outputs quiet.
      applyStimulus(0, 2'b11, 32'h140, 32'h77777777, 0, 32'h0);
      checkOutput("rw_req", 1, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 2'b11, 32'h140, 32'h77777777, 0, 32'h0);
      checkOutput("rw_write", 1, 32'h0, 1, 1, 32'h140, 32'h77777777);
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("rw_abort", 0, 32'h0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 2'b00, 32'h140, 32'h0, 1, 32'h0);
      rst = 1'b0;
      checkOutput("rw_140_miss", 1, 32'h0, 0, 0, 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
